// File: rtl/mc_controller_stall.sv
// Multicycle RISC-V main controller with a variable-latency memory handshake,
// a per-access timeout, illegal-instruction halt and a retired-instruction counter.
module mc_controller_stall #(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                zero_i,
  input  logic                sign_i,
  input  logic [6:0]          opcode_i,
  input  logic [2:0]          func3_i,
  input  logic [6:0]          func7_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                adr_src_o,
  output logic                mem_write_o,
  output logic                ir_write_o,
  output logic                reg_write_o,
  output logic [1:0]          result_src_o,
  output logic [1:0]          alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [2:0]          alu_control_o,
  output logic [2:0]          imm_src_o,
  output logic                mem_req_o,
  output logic                halted_o,
  output logic [RETIRE_W-1:0] retired_o
);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StExecI, StAluWb, StMemAdr, StMemRd,
    StMemWb, StMemWr, StBranch, StJalrAdr, StJal, StLui, StHalt
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            wait_q, wait_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;

  logic       done;
  logic       timeout;
  logic       alu_legal;
  logic [2:0] alu_op;
  logic       unused_func7;

  assign unused_func7 = ^{func7_i[6], func7_i[4:0]};
  assign done         = MEM_WAIT_EN ? mem_ready_i : 1'b1;
  // Last permitted wait cycle without ready ends the access.
  assign timeout      = !done && (wait_q == 8'(MEM_TIMEOUT - 1));
  assign retired_o    = retired_q;

  // func3/func7 to ALU operation for register and immediate arithmetic
  always_comb begin
    alu_legal = 1'b1;
    alu_op    = AluAdd;
    case (func3_i)
      3'b000:  alu_op = (state_q == StExecR && func7_i[5]) ? AluSub : AluAdd;
      3'b111:  alu_op = AluAnd;
      3'b110:  alu_op = AluOr;
      3'b100:  alu_op = AluXor;
      3'b010:  alu_op = AluSlt;
      default: alu_legal = 1'b0;
    endcase
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d       = state_q;
    pc_write_o    = 1'b0;
    adr_src_o     = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    reg_write_o   = 1'b0;
    result_src_o  = 2'b00;
    alu_src_a_o   = 2'b00;
    alu_src_b_o   = 2'b00;
    alu_control_o = AluAdd;
    imm_src_o     = ImmI;
    mem_req_o     = 1'b0;
    halted_o      = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        if (done) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = StDecode;
        end else if (timeout) begin
          state_d = StHalt;
        end
      end
      StDecode: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        imm_src_o   = (opcode_i == OpBr) ? ImmB : (opcode_i == OpJal) ? ImmJ : ImmI;
        case (opcode_i)
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpLoad, OpStore: state_d = StMemAdr;
          OpBr:            state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalrAdr;
          OpLui:           state_d = StLui;
          default:         state_d = StHalt;
        endcase
      end
      StExecR, StExecI: begin
        alu_src_a_o   = 2'b10;
        alu_src_b_o   = (state_q == StExecI) ? 2'b01 : 2'b00;
        alu_control_o = alu_op;
        state_d       = alu_legal ? StAluWb : StHalt;
      end
      StAluWb: begin
        reg_write_o = 1'b1;
        state_d     = StFetch;
      end
      StMemAdr: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        imm_src_o   = (opcode_i == OpStore) ? ImmS : ImmI;
        state_d     = (opcode_i == OpStore) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        if (done)         state_d = StMemWb;
        else if (timeout) state_d = StHalt;
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        result_src_o = 2'b01;
        state_d      = StFetch;
      end
      StMemWr: begin
        mem_req_o   = 1'b1;
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
        if (done)         state_d = StFetch;
        else if (timeout) state_d = StHalt;
      end
      StBranch: begin
        alu_src_a_o   = 2'b10;
        alu_control_o = AluSub;
        state_d       = StFetch;
        case (func3_i)
          3'b000:  pc_write_o = zero_i;
          3'b001:  pc_write_o = !zero_i;
          3'b100:  pc_write_o = sign_i;
          3'b101:  pc_write_o = !sign_i;
          default: state_d = StHalt;
        endcase
      end
      StJalrAdr: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = StJal;
      end
      StJal: begin
        pc_write_o  = 1'b1;
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        state_d     = StAluWb;
      end
      StLui: begin
        reg_write_o  = 1'b1;
        result_src_o = 2'b11;
        imm_src_o    = ImmU;
        state_d      = StFetch;
      end
      StHalt:  halted_o = 1'b1;
      default: state_d = StHalt;
    endcase
    // Reset silences every output, including the Mealy strobes.
    if (rst_i) begin
      pc_write_o    = 1'b0;
      adr_src_o     = 1'b0;
      mem_write_o   = 1'b0;
      ir_write_o    = 1'b0;
      reg_write_o   = 1'b0;
      result_src_o  = 2'b00;
      alu_src_a_o   = 2'b00;
      alu_src_b_o   = 2'b00;
      alu_control_o = AluAdd;
      imm_src_o     = ImmI;
      mem_req_o     = 1'b0;
      halted_o      = 1'b0;
    end
  end

  // Wait counter and retired-instruction counter updates
  always_comb begin
    retired_d = retired_q;
    wait_d    = wait_q;
    if (state_d == StFetch &&
        state_q inside {StAluWb, StMemWb, StMemWr, StBranch, StLui}) begin
      retired_d = retired_q + RETIRE_W'(1);
    end
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (state_q inside {StFetch, StMemRd, StMemWr}) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StFetch;
      wait_q    <= 8'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_mc_controller_stall.sv
// Randomized bench: each instruction is expanded into its expected per-cycle output
// sequence from the instruction-level timing rules, then replayed against the DUT.
module tb_mc_controller_stall;

  localparam int TO = 4;
  localparam int RW = 4;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic zero = 1'b0, sign = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = 7'd0, func7 = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, mem_req, halted;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;
  logic [RW-1:0] retired;
  logic [18:0] outs;

  assign outs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
                 alu_src_b, alu_control, imm_src, mem_req, halted};

  mc_controller_stall #(.MEM_WAIT_EN(1'b1), .MEM_TIMEOUT(TO), .RETIRE_W(RW)) dut (
    .clk_i(clk), .rst_i(rst), .zero_i(zero), .sign_i(sign), .opcode_i(opcode),
    .func3_i(func3), .func7_i(func7), .mem_ready_i(mem_ready), .pc_write_o(pc_write),
    .adr_src_o(adr_src), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .reg_write_o(reg_write), .result_src_o(result_src), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_control_o(alu_control), .imm_src_o(imm_src),
    .mem_req_o(mem_req), .halted_o(halted), .retired_o(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic [18:0] exp;
  } cyc_t;

  cyc_t q[$];
  int   nvec = 0, nerr = 0;
  int   ret_model = 0;
  bit   m_halt, m_ret;
  logic [6:0] cur_op, cur_f7;
  logic [2:0] cur_f3;
  logic cur_z, cur_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %h want %h (op %b f3 %b)", tag, $time, got, exp,
               cur_op, cur_f3);
    end
  endtask

  function automatic logic [18:0] v(input logic pcw, adr, mw, irw, rw,
                                    input logic [1:0] rs, a, b,
                                    input logic [2:0] ctl, imm, input logic req, hlt);
    return {pcw, adr, mw, irw, rw, rs, a, b, ctl, imm, req, hlt};
  endfunction

  function automatic bit alu_map(input logic [2:0] f3, input bit sub, output logic [2:0] ctl);
    ctl = 3'b000;
    case (f3)
      3'b000:  ctl = sub ? 3'b001 : 3'b000;
      3'b111:  ctl = 3'b010;
      3'b110:  ctl = 3'b011;
      3'b100:  ctl = 3'b100;
      3'b010:  ctl = 3'b101;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic push(input logic [18:0] e);
    cyc_t c;
    c.rdy = 1'($urandom_range(0, 1));  // stray ready pulses must be ignored
    c.exp = e;
    q.push_back(c);
  endtask

  task automatic push_halt();
    m_halt = 1'b1;
    for (int i = 0; i < 3; i++) push(19'b1);
  endtask

  // Memory phase: ready on cycle dly, or give up after TO cycles without ready.
  task automatic mem_phase(input logic [18:0] base, input logic [18:0] extra, input int dly,
                           output bit to);
    cyc_t c;
    to = 1'b1;
    for (int i = 0; i < TO; i++) begin
      c.rdy = (i == dly);
      c.exp = c.rdy ? (base | extra) : base;
      q.push_back(c);
      if (c.rdy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  // Expected cycle sequence of one instruction.
  task automatic build(input int fd, input int md);
    bit to, legal;
    logic [2:0] ctl, imm;
    logic taken;
    q.delete();
    m_halt = 1'b0;
    m_ret  = 1'b0;
    mem_phase(v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1, 0),
              v(1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0), fd, to);
    if (to) begin
      push_halt();
      return;
    end
    imm = (cur_op == OpBr) ? 3'b010 : (cur_op == OpJal) ? 3'b011 : 3'b000;
    push(v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0));
    case (cur_op)
      OpR, OpI: begin
        legal = alu_map(cur_f3, (cur_op == OpR) && cur_f7[5], ctl);
        push(v(0, 0, 0, 0, 0, 2'b00, 2'b10, (cur_op == OpI) ? 2'b01 : 2'b00, ctl, 3'b000,
               0, 0));
        if (!legal) begin
          push_halt();
          return;
        end
        push(v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
      end
      OpLoad: begin
        push(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
        mem_phase(v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0), 19'd0, md, to);
        if (to) begin
          push_halt();
          return;
        end
        push(v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
      end
      OpStore: begin
        push(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0, 0));
        mem_phase(v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0), 19'd0, md, to);
        if (to) begin
          push_halt();
          return;
        end
      end
      OpBr: begin
        legal = 1'b1;
        taken = 1'b0;
        case (cur_f3)
          3'b000:  taken = cur_z;
          3'b001:  taken = !cur_z;
          3'b100:  taken = cur_s;
          3'b101:  taken = !cur_s;
          default: legal = 1'b0;
        endcase
        push(v(taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0, 0));
        if (!legal) begin
          push_halt();
          return;
        end
      end
      OpJal, OpJalr: begin
        if (cur_op == OpJalr) push(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0, 0));
        push(v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0, 0));
        push(v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
      end
      OpLui: push(v(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 0, 0));
      default: begin
        push_halt();
        return;
      end
    endcase
    m_ret = 1'b1;
  endtask

  task automatic play(input int upto);
    for (int k = 0; k < upto && k < q.size(); k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        rst = 1'b0; opcode = cur_op; func3 = cur_f3; func7 = cur_f7;
        zero = cur_z; sign = cur_s;
      end
      mem_ready = q[k].rdy;
      @(negedge clk);
      if (k == 0) check("retired", 32'(retired), 32'(ret_model % (1 << RW)));
      check("outputs", 32'(outs), 32'(q[k].exp));
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      mem_ready = 1'b1;
      opcode = 7'($urandom);
      zero = 1'b1;
      @(negedge clk);
      check("reset_outputs", 32'(outs), 32'd0);
    end
    ret_model = 0;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input logic s, input int fd, input int md,
                           input int abort);
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z; cur_s = s;
    build(fd, md);
    if (abort > 0 && abort < q.size()) begin
      play(abort);
      do_reset();
    end else begin
      play(q.size());
      if (m_halt) begin
        check("retired_halt", 32'(retired), 32'(ret_model % (1 << RW)));
        do_reset();
      end else if (m_ret) begin
        ret_model = ret_model + 1;
      end
    end
  endtask

  function automatic int rnd_dly();
    return ($urandom_range(0, 19) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
  endfunction

  logic [6:0] ops [9];

  initial begin
    ops = '{OpR, OpI, OpLoad, OpStore, OpBr, OpJal, OpJalr, OpLui, 7'b1111111};
    do_reset();
    // add, then fetch with a 3-cycle wait, then branches
    run_instr(OpR, 3'b000, 7'd0, 0, 0, 0, 0, 0);
    run_instr(OpR, 3'b000, 7'b0100000, 0, 0, 3, 0, 0);
    run_instr(OpBr, 3'b000, 7'd0, 1, 0, 0, 0, 0);
    run_instr(OpBr, 3'b001, 7'd0, 1, 0, 0, 0, 0);
    run_instr(OpBr, 3'b100, 7'd0, 0, 1, 0, 0, 0);
    run_instr(OpJalr, 3'b000, 7'd0, 0, 0, 1, 0, 0);
    run_instr(OpJal, 3'b000, 7'd0, 0, 0, 0, 0, 0);
    run_instr(OpLoad, 3'b010, 7'd0, 0, 0, 0, 3, 0);
    run_instr(OpStore, 3'b010, 7'd0, 0, 0, 2, 1, 0);
    run_instr(OpLui, 3'b000, 7'd0, 0, 0, 0, 0, 0);
    run_instr(OpI, 3'b000, 7'b0100000, 0, 0, 0, 0, 0);
    // store that never completes, then an illegal opcode
    run_instr(OpStore, 3'b010, 7'd0, 0, 0, 0, 100, 0);
    run_instr(7'b1111111, 3'b000, 7'd0, 0, 0, 0, 0, 0);
    // abort a store in its write phase
    run_instr(OpStore, 3'b010, 7'd0, 0, 0, 0, 2, 4);
    // 16 retirements wrap the 4-bit counter
    do_reset();
    for (int i = 0; i < 16; i++) run_instr(OpLui, 3'b000, 7'd0, 0, 0, 0, 0, 0);
    run_instr(OpR, 3'b110, 7'd0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      int idx;
      idx = int'($urandom_range(0, 9));
      op  = (idx == 9) ? 7'($urandom) : ops[idx];
      run_instr(op, 3'($urandom), 7'($urandom), 1'($urandom), 1'($urandom), rnd_dly(),
                rnd_dly(), ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, 6)) : 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mc_controller_stall.md
# mc_controller_stall

Parametrised multicycle RISC-V main controller, the successor to the fixed-timing controller in the multicycle core. It drives the same datapath strobes and adds a variable-latency memory handshake (`mem_req`/`mem_ready`) with a timeout. It also halts on illegal opcodes and keeps a retired-instruction counter. It drops into the top level beside `Datapath`, and the core's memory gains a ready output.

## Interface
- `MEM_WAIT_EN`, default 1. 1: memory states wait for `mem_ready`. 0: `mem_ready` is ignored and every memory access completes in 1 cycle.
- `MEM_TIMEOUT`, default 16. Maximum cycles spent in one memory state before halting. Range 1..255.
- `RETIRE_W`, default 32. Width of the retired counter.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `zero`, `sign`  in  1 each  ALU result flags.
- `opcode`  in  7  instruction opcode field.
- `func3`  in  3  instruction func3 field.
- `func7`  in  7  instruction func7 field.
- `mem_ready`  in  1  memory access completes this cycle.
- `PCWrite`, `AdrSrc`, `MemWrite`, `IRWrite`, `RegWrite`  out  1 each  datapath strobes.
- `ResultSrc`  out  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult, 11 Imm.
- `ALUSrcA`  out  2  ALU A select: 00 PC, 01 OldPC, 10 RS1.
- `ALUSrcB`  out  2  ALU B select: 00 RS2, 01 Imm, 10 constant 4.
- `ALUControl`  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- `ImmSrc`  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- `mem_req`  out  1  memory access request.
- `halted`  out  1  controller is in HALT.
- `retired`  out  `RETIRE_W`  count of completed instructions.

## Operation
- Any output not listed in a state below is 0. "Done" means `mem_ready`=1, or always true when `MEM_WAIT_EN`=0.
- **FETCH:** `mem_req`=1, `AdrSrc`=0, ALU computes PC+4 (A=00, B=10, add), `ResultSrc`=10.
  - `IRWrite` and `PCWrite` assert only in the done cycle (Mealy on `mem_ready`). Then go to DECODE.
- **DECODE:** ALU computes OldPC+Imm (A=01, B=01, add) into ALUOut, with `ImmSrc`=B for branches, J for jal, I otherwise. Next state by opcode:
  - 0110011 → EXEC_R; 0010011 → EXEC_I; 0000011 or 0100011 → MEM_ADR.
  - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR_ADR; 0110111 → LUI.
  - Any other opcode → HALT.
- **EXEC_R:** A=10, B=00. ALUControl from func3/func7:
  - 000 add, or sub when `func7[5]`=1; 111 and; 110 or; 100 xor; 010 slt.
  - Any other func3 → HALT.
  - Otherwise → ALU_WB.
- **EXEC_I:** A=10, B=01, `ImmSrc`=I. Same func3 map as EXEC_R; func7 is ignored (no sub). → ALU_WB.
- **ALU_WB:** `RegWrite`=1, `ResultSrc`=00. → FETCH.
- **MEM_ADR:** A=10, B=01, add, `ImmSrc`=I for loads and S for stores. → MEM_RD for loads, MEM_WR for stores.
- **MEM_RD:** `mem_req`=1, `AdrSrc`=1. On done → MEM_WB.
- **MEM_WB:** `RegWrite`=1, `ResultSrc`=01. → FETCH.
- **MEM_WR:** `mem_req`=1, `AdrSrc`=1, `MemWrite`=1, held until done. On done → FETCH.
- **BRANCH:** A=10, B=00, sub, `ResultSrc`=00. → FETCH.
  - `PCWrite` is Mealy on the flags: beq `zero`, bne `!zero`, blt `sign`, bge `!sign`.
  - Any other func3 → HALT, with no `PCWrite`.
- **JALR_ADR:** ALU computes RS1+Imm (A=10, B=01, `ImmSrc`=I, add). → JAL.
- **JAL:** `PCWrite`=1, `ResultSrc`=00 (target from ALUOut); ALU computes OldPC+4 (A=01, B=10, add). → ALU_WB.
- **LUI:** `RegWrite`=1, `ResultSrc`=11, `ImmSrc`=U. → FETCH.
- **HALT:** absorbing state; `halted`=1 and all strobes 0. Only `rst` leaves it.
- **Timeout:** a wait counter clears on entering FETCH, MEM_RD or MEM_WR and increments each cycle without done.
  - Reaching `MEM_TIMEOUT` without done → HALT. No strobe fires in that cycle.
- **Retire counter:** `retired` increments by 1 on every transition into FETCH from ALU_WB, MEM_WB, MEM_WR, BRANCH or LUI. It wraps modulo 2^`RETIRE_W`.

## Timing
- On reset: state=FETCH, `retired`=0, `halted`=0, wait counter=0.
  - All strobes read 0 in any cycle where `rst`=1, including the Mealy strobes.
- `rst` mid-instruction aborts it the next edge. There is no partial `RegWrite` or `MemWrite`.
- Cycle counts with `MEM_WAIT_EN`=0:
  - R/I-type, jal, jalr: 4 (jalr is 5).
  - lw: 5; sw: 4; beq: 3; lui: 3.
- Each memory state adds its wait cycles (ready cycle minus 1).
- A `mem_ready` pulse outside FETCH, MEM_RD or MEM_WR is ignored.
- `mem_ready` arriving exactly at wait count `MEM_TIMEOUT`-1 is still accepted.

## Test plan
- **Reset and fetch:** `rst` for 2 cycles, then `mem_ready`=1 and opcode 0110011 (add) → FETCH/DECODE/EXEC_R/ALU_WB. `RegWrite` pulses in cycle 4, and `retired`=1 at cycle 5.
- **Fetch wait:** `mem_ready` rises 3 cycles after FETCH entry → `IRWrite` and `PCWrite` stay low for 3 cycles, then pulse exactly once. `mem_req` is high for 4 cycles.
- **Branches:** beq with `zero`=1 → `PCWrite`=1 in BRANCH. bne with `zero`=1 → `PCWrite`=0. blt with `sign`=1 → `PCWrite`=1. `retired` increments in all cases.
- **Timeout:** sw with `mem_ready` held 0 and `MEM_TIMEOUT`=4 → `MemWrite` high for 4 cycles, then `halted`=1 permanently and `retired` unchanged.
- **Illegal opcode:** opcode 1111111 → HALT after DECODE. A later `rst` gives `retired`=0 and `halted`=0.
- **jalr and wrap:** jalr → states JALR_ADR, JAL, ALU_WB with `PCWrite` in JAL and `RegWrite` in ALU_WB. With `RETIRE_W`=4, 16 retired instructions → `retired`=0.
